// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt dispatcher.
package irq_pkg;

  localparam int unsigned NIRQ = 16;
  localparam int unsigned IW   = 4;

  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_EDGE = 2'd1;
  localparam logic [1:0] CFG_CLR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DELIVER  = 2'd1,
    WAIT_ACK = 2'd2,
    SERVICE  = 2'd3
  } state_e;

  function automatic logic [NIRQ-1:0] bit_of(input logic [IW-1:0] idx);
    return NIRQ'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index of the lowest set bit, bit 0 wins.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [NIRQ-1:0] vec,
  output logic [IW-1:0]   idx_c,
  output logic            valid_c
);

  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx_c   = IW'(i);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: synchronizes 16 lines, tracks level/edge pending state and delivers the
// lowest-index eligible line to the frontend. Define IRQ_NESTING_EN to allow preemption in SERVICE.
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int unsigned RETRY_CYC = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq_line,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_sel,
  input  logic [NIRQ-1:0] cfg_wdata,
  input  logic            irq_ack,
  input  logic            irq_eoi,
  output logic            irqload,
  output logic [IW-1:0]   irqnum,
  output logic [NIRQ-1:0] irq_pending,
  output logic [NIRQ-1:0] irq_in_service
);

  localparam int unsigned CW = 8;
  // DELIVER, the WAIT_ACK window and the IDLE re-arbitration together span RETRY_CYC+1 cycles.
  localparam logic [CW-1:0] TMO = CW'((RETRY_CYC > 1) ? RETRY_CYC - 2 : 0);

  logic [NIRQ-1:0] s1, s2, s3;
  logic [NIRQ-1:0] mask, edge_mode;
  state_e          state;
  logic [CW-1:0]   cnt;

  logic [NIRQ-1:0] clr_c, rise_c, pend_nxt_c, eligible_c, eoi_bit_c;
  logic [IW-1:0]   sel_idx_c;
  logic            sel_vld_c, preempt_c;

  // Edge pending bits: a fresh rise beats a same-cycle clear from cfg or ack.
  always_comb begin
    clr_c = '0;
    if (cfg_we && cfg_sel == CFG_CLR) clr_c = cfg_wdata;
    if (state == WAIT_ACK && irq_ack) clr_c = clr_c | bit_of(irqnum);
    rise_c     = s2 & ~s3;
    pend_nxt_c = (s2 & ~edge_mode) | (((irq_pending & ~clr_c) | rise_c) & edge_mode);
    eligible_c = irq_pending & ~mask & ~irq_in_service;
  end

  irq_prio_enc u_sel_enc (
    .vec     (eligible_c),
    .idx_c   (sel_idx_c),
    .valid_c (sel_vld_c)
  );

`ifdef IRQ_NESTING_EN
  logic [IW-1:0] isr_idx_c;
  logic          isr_vld_c;

  irq_prio_enc u_isr_enc (
    .vec     (irq_in_service),
    .idx_c   (isr_idx_c),
    .valid_c (isr_vld_c)
  );

  assign preempt_c = sel_vld_c && (!isr_vld_c || (sel_idx_c < isr_idx_c));
  assign eoi_bit_c = bit_of(isr_idx_c);
`else
  assign preempt_c = 1'b0;
  assign eoi_bit_c = bit_of(irqnum);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1             <= '0;
      s2             <= '0;
      s3             <= '0;
      mask           <= '1;
      edge_mode      <= '0;
      irq_pending    <= '0;
      irq_in_service <= '0;
      state          <= IDLE;
      cnt            <= '0;
      irqload        <= 1'b0;
      irqnum         <= '0;
    end else begin
      s1          <= irq_line;
      s2          <= s1;
      s3          <= s2;
      irq_pending <= pend_nxt_c;
      irqload     <= 1'b0;

      if (cfg_we) begin
        case (cfg_sel)
          CFG_MASK: mask      <= cfg_wdata;
          CFG_EDGE: edge_mode <= cfg_wdata;
          default:  ;
        endcase
      end

      case (state)
        IDLE: begin
          if (sel_vld_c) begin
            irqnum  <= sel_idx_c;
            irqload <= 1'b1;
            state   <= DELIVER;
          end
        end
        DELIVER: begin
          cnt   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (irq_ack) begin
            irq_in_service <= irq_in_service | bit_of(irqnum);
            state          <= SERVICE;
          end else if (cnt == TMO) begin
            // A timed-out preemption falls back to the interrupted handler.
            state <= (|irq_in_service) ? SERVICE : IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SERVICE: begin
          if (irq_eoi && (|irq_in_service)) begin
            irq_in_service <= irq_in_service & ~eoi_bit_c;
            state          <= (|(irq_in_service & ~eoi_bit_c)) ? SERVICE : IDLE;
          end else if (preempt_c) begin
            irqnum  <= sel_idx_c;
            irqload <= 1'b1;
            state   <= DELIVER;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
